// File: rtl/usb_pkt_pkg.sv
// Shared USB packet definitions for the peripheral receive path.
// Widths mirror the lycan_globals values: a 32-bit USB packet made of a
// 3-bit peripheral address followed by a 29-bit peripheral body.
package usb_pkt_pkg;

  localparam int usb_packet_width     = 32;
  localparam int periph_address_width = 3;
  localparam int periph_body_width    = usb_packet_width - periph_address_width;

  typedef logic [periph_body_width-1:0]    periph_body_t;
  typedef logic [periph_address_width-1:0] periph_addr_t;

  typedef struct packed {
    periph_addr_t addr;
    periph_body_t body;
  } usb_pkt_t;

endpackage

// File: rtl/periph_rx_slot_fifo.sv
// Per-peripheral receive FIFO.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   wren, din  : write strobe and packet body from the peripheral
//   rden       : pop the head entry (ignored while empty)
//   dout       : head entry (valid while !empty)
//   count      : number of stored entries, 0..FIFO_DEPTH
//   full/empty : count == FIFO_DEPTH / count == 0
// A write while full is still accepted when the same cycle pops, so a slot
// drained at full rate never loses data.
module periph_rx_slot_fifo
  import usb_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wren,
  input  logic [periph_body_width-1:0] din,
  input  logic                         rden,
  output logic [periph_body_width-1:0] dout,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         empty
);

  localparam logic [CNT_W-1:0] depth_c = CNT_W'(FIFO_DEPTH);

  periph_body_t     mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             rd_s;
  logic             wr_s;

  // Status flags and accepted write/pop qualification.
  always_comb begin
    full_s  = (count_r == depth_c);
    empty_s = (count_r == {CNT_W{1'b0}});
    rd_s    = rden && !empty_s;
    wr_s    = wren && (!full_s || rd_s);
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/periph_rx_arbiter.sv
// Merges per-peripheral 29-bit receive packets into one 32-bit USB stream.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   rx_data      : per-slot packet body
//   rx_wren      : per-slot single-cycle write strobe
//   rx_full      : per-slot FIFO full (combinational from registered count)
//   pkt_data     : registered {slot, body}
//   pkt_valid    : pkt_data holds a packet
//   pkt_ready    : consumer accepts pkt_data on this edge when pkt_valid
//   overflow     : sticky per-slot drop flag
//   overflow_clr : per-slot clear for overflow (a same-cycle set wins)
// Slot index doubles as the peripheral address, so NUM_PERIPHS must not
// exceed 2**periph_address_width.
module periph_rx_arbiter
  import usb_pkt_pkg::*;
#(
  parameter int NUM_PERIPHS = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_PERIPHS-1:0][periph_body_width-1:0] rx_data,
  input  logic [NUM_PERIPHS-1:0]                        rx_wren,
  output logic [NUM_PERIPHS-1:0]                        rx_full,
  output logic [usb_packet_width-1:0]                   pkt_data,
  output logic                                          pkt_valid,
  input  logic                                          pkt_ready,
  output logic [NUM_PERIPHS-1:0]                        overflow,
  input  logic [NUM_PERIPHS-1:0]                        overflow_clr
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] depth_c = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]       count_s [NUM_PERIPHS];
  periph_body_t           head_s  [NUM_PERIPHS];
  logic [NUM_PERIPHS-1:0] full_s;
  logic [NUM_PERIPHS-1:0] empty_s;
  logic [NUM_PERIPHS-1:0] rden_s;
  logic [NUM_PERIPHS-1:0] drop_s;
  periph_addr_t           last_grant_r;
  periph_addr_t           winner_s;
  periph_addr_t           scan_addr_s;
  int                     scan_idx_s;
  logic                   found_s;
  logic                   load_s;
  usb_pkt_t               pkt_r;
  logic                   pkt_valid_r;
  logic [NUM_PERIPHS-1:0] overflow_r;

  for (genvar i = 0; i < NUM_PERIPHS; i++) begin : g_slot
    periph_rx_slot_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wren  (rx_wren[i]),
      .din   (rx_data[i]),
      .rden  (rden_s[i]),
      .dout  (head_s[i]),
      .count (count_s[i]),
      .full  (full_s[i]),
      .empty (empty_s[i])
    );

    assign rden_s[i] = load_s && (winner_s == periph_addr_t'(i));
    // The FIFO accepts a write-when-full only alongside a pop, so a drop is
    // exactly the complementary case.
    assign drop_s[i] = rx_wren[i] && (count_s[i] == depth_c) && !rden_s[i];
  end

  // Round-robin scan: first non-empty slot after last_grant, wrapping.
  always_comb begin
    winner_s    = last_grant_r;
    found_s     = 1'b0;
    scan_idx_s  = 0;
    scan_addr_s = last_grant_r;
    for (int k = 1; k <= NUM_PERIPHS; k++) begin
      scan_idx_s  = (int'(last_grant_r) + k) % NUM_PERIPHS;
      scan_addr_s = periph_addr_t'(scan_idx_s);
      if (!found_s && !empty_s[scan_addr_s]) begin
        found_s  = 1'b1;
        winner_s = scan_addr_s;
      end else begin
        found_s  = found_s;
      end
    end
    load_s = (!pkt_valid_r || pkt_ready) && found_s;
  end

  // Output register and grant pointer; slot 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_r        <= usb_pkt_t'({usb_packet_width{1'b0}});
      pkt_valid_r  <= 1'b0;
      last_grant_r <= periph_addr_t'(NUM_PERIPHS - 1);
    end else if (load_s) begin
      pkt_r.addr   <= winner_s;
      pkt_r.body   <= head_s[winner_s];
      pkt_valid_r  <= 1'b1;
      last_grant_r <= winner_s;
    end else if (pkt_ready && pkt_valid_r) begin
      pkt_valid_r  <= 1'b0;
    end
  end

  // Sticky drop flags; a new drop outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= {NUM_PERIPHS{1'b0}};
    end else begin
      overflow_r <= drop_s | (overflow_r & ~overflow_clr);
    end
  end

  assign rx_full   = full_s;
  assign pkt_data  = pkt_r;
  assign pkt_valid = pkt_valid_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// Directed self-checking bench for periph_rx_arbiter (8 slots, depth 4).
module tb_periph_rx_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0][28:0] rx_data;
  logic [7:0]       rx_wren;
  logic [7:0]       rx_full;
  logic [31:0]      pkt_data;
  logic             pkt_valid;
  logic             pkt_ready;
  logic [7:0]       overflow;
  logic [7:0]       overflow_clr;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_rr [6];

  always #5 clk = ~clk;

  periph_rx_arbiter #(
    .NUM_PERIPHS(8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_wren      (rx_wren),
    .rx_full      (rx_full),
    .pkt_data     (pkt_data),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] s, input logic [28:0] b);
    rx_data[s] = b;
    rx_wren[s] = 1'b1;
  endtask

  task automatic do_reset;
    rst_n        = 1'b0;
    rx_data      = '0;
    rx_wren      = 8'h00;
    overflow_clr = 8'h00;
    pkt_ready    = 1'b0;
    tick;
    tick;
    rst_n        = 1'b1;
  endtask

  initial begin
    do_reset;
    check("rst_valid",    32'(pkt_valid), 32'h0);
    check("rst_data",     pkt_data,       32'h0);
    check("rst_overflow", 32'(overflow),  32'h0);
    check("rst_full",     32'(rx_full),   32'h0);

    // Single packet on slot 2
    pkt_ready = 1'b1;
    put(3'd2, 29'h0300_00AB);
    tick;
    rx_wren = 8'h00;
    check("t1_not_yet", 32'(pkt_valid), 32'h0);
    tick;
    check("t1_valid", 32'(pkt_valid), 32'h1);
    check("t1_data",  pkt_data,       32'h4300_00AB);
    tick;
    check("t1_drop", 32'(pkt_valid), 32'h0);

    // Round-robin across slots 0, 3, 5 (slot 5 second body has config-response top bits)
    do_reset;
    put(3'd0, 29'h0000_0001); put(3'd3, 29'h0000_0031); put(3'd5, 29'h1000_0051);
    tick;
    put(3'd0, 29'h0000_0002); put(3'd3, 29'h0000_0032); put(3'd5, 29'h1C00_0052);
    tick;
    rx_wren = 8'h00;
    exp_rr = '{32'h0000_0001, 32'h6000_0031, 32'hB000_0051,
               32'h0000_0002, 32'h6000_0032, 32'hBC00_0052};
    check("rr_data0", pkt_data, exp_rr[0]);
    pkt_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick;
      check("rr_valid", 32'(pkt_valid), 32'h1);
      check("rr_data",  pkt_data,       exp_rr[i]);
    end
    tick;
    check("rr_empty", 32'(pkt_valid), 32'h0);

    // Backpressure on slot 1
    do_reset;
    put(3'd1, 29'h0000_00D0);
    tick;
    put(3'd1, 29'h0000_00D1);
    tick;
    rx_wren = 8'h00;
    for (int i = 0; i < 10; i++) begin
      check("bp_data",  pkt_data,                 32'h2000_00D0);
      check("bp_count", 32'(dut.count_s[1]),      32'h1);
      tick;
    end
    check("bp_valid", 32'(pkt_valid), 32'h1);
    pkt_ready = 1'b1;
    tick;
    check("bp_next", pkt_data,        32'h2000_00D1);
    check("bp_nv",   32'(pkt_valid),  32'h1);
    tick;
    check("bp_done", 32'(pkt_valid),  32'h0);

    // Overflow on slot 4
    do_reset;
    for (int k = 1; k <= 3; k++) begin
      put(3'd4, 29'h0000_0040 + 29'(k));
      tick;
    end
    check("ov_out1",   pkt_data,              32'h8000_0041);
    check("ov_cnt2",   32'(dut.count_s[4]),   32'h2);
    check("ov_full0",  32'(rx_full),          32'h0);
    for (int k = 4; k <= 5; k++) begin
      put(3'd4, 29'h0000_0040 + 29'(k));
      tick;
    end
    rx_wren = 8'h00;
    check("ov_cnt4",   32'(dut.count_s[4]),   32'h4);
    check("ov_full1",  32'(rx_full),          32'h10);
    check("ov_none",   32'(overflow),         32'h0);
    put(3'd4, 29'h0000_0046);
    tick;
    rx_wren = 8'h00;
    check("ov_set",    32'(overflow),         32'h10);
    check("ov_keep4",  32'(dut.count_s[4]),   32'h4);
    put(3'd4, 29'h0000_0047);
    overflow_clr = 8'h10;
    tick;
    rx_wren = 8'h00;
    check("ov_setwins", 32'(overflow),        32'h10);
    tick;
    overflow_clr = 8'h00;
    check("ov_clr",    32'(overflow),         32'h0);
    check("ov_hold1",  pkt_data,              32'h8000_0041);
    pkt_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick;
      check("ov_drain", pkt_data, 32'h8000_0040 + 32'(k));
    end
    tick;
    check("ov_end", 32'(pkt_valid), 32'h0);

    // Write-with-pop on a full slot 0
    do_reset;
    for (int k = 1; k <= 5; k++) begin
      put(3'd0, 29'h0ABC_DE00 + 29'(k));
      tick;
    end
    rx_wren = 8'h00;
    check("wp_full", 32'(rx_full), 32'h01);
    pkt_ready = 1'b1;
    put(3'd0, 29'h0ABC_DE06);
    tick;
    rx_wren = 8'h00;
    check("wp_cnt",  32'(dut.count_s[0]), 32'h4);
    check("wp_ovf",  32'(overflow),       32'h0);
    check("wp_out2", pkt_data,            32'h0ABC_DE02);
    for (int k = 3; k <= 6; k++) begin
      tick;
      check("wp_drain", pkt_data, 32'h0ABC_DE00 + 32'(k));
    end
    tick;
    check("wp_end", 32'(pkt_valid), 32'h0);

    // Async reset mid-stream
    do_reset;
    for (int k = 1; k <= 6; k++) begin
      put(3'd6, 29'h0000_0060 + 29'(k));
      tick;
    end
    rx_wren = 8'h00;
    check("ar_pre_full", 32'(rx_full),  32'h40);
    check("ar_pre_ovf",  32'(overflow), 32'h40);
    pkt_ready = 1'b1;
    tick;
    tick;
    check("ar_pre_valid", 32'(pkt_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(pkt_valid), 32'h0);
    check("ar_full",  32'(rx_full),   32'h0);
    check("ar_ovf",   32'(overflow),  32'h0);
    check("ar_data",  pkt_data,       32'h0);
    #2;
    rst_n = 1'b1;
    put(3'd5, 29'h0000_0055);
    put(3'd2, 29'h0000_0022);
    tick;
    rx_wren = 8'h00;
    check("ar_idle", 32'(pkt_valid), 32'h0);
    tick;
    check("ar_first",  pkt_data, 32'h4000_0022);
    tick;
    check("ar_second", pkt_data, 32'hA000_0055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/periph_rx_arbiter.md
# periph_rx_arbiter

Collects 29-bit receive packets written by every peripheral (UART, SPI, …) and merges them into one stream of 32-bit USB packets for the USB transmit path. Each packet gets its peripheral's 3-bit address prepended. The block has one small FIFO per peripheral so that peripherals see only `rx_wren`/`rx_full`, a round-robin arbiter across the FIFOs, and a registered valid/ready output stage.

## Interface
- `NUM_PERIPHS`, default 8: number of peripheral slots; slot index equals peripheral address.
- `FIFO_DEPTH`, default 4: entries per slot FIFO; power of two, at least 2.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in `NUM_PERIPHS`×29: per-slot packet body (`usb_packet_width - periph_address_width`).
- `rx_wren` in `NUM_PERIPHS`: per-slot single-cycle write strobe.
- `rx_full` out `NUM_PERIPHS`: per-slot FIFO full (count == `FIFO_DEPTH`).
- `pkt_data` out 32: `{slot[2:0], body[28:0]}`.
- `pkt_valid` out 1: `pkt_data` holds a packet.
- `pkt_ready` in 1: the consumer accepts the packet on this edge if `pkt_valid` is high.
- `overflow` out `NUM_PERIPHS`: sticky per-slot drop flag.
- `overflow_clr` in `NUM_PERIPHS`: per-slot clear for `overflow`.

## Operation
**Reset values**
- `pkt_valid` = 0, `pkt_data` = 0, `overflow` = 0, `rx_full` = 0.
- All FIFO counts = 0; round-robin pointer `last_grant` = `NUM_PERIPHS`-1, so slot 0 has first priority.

**Slot write**
- A write on `rx_wren[i]` is accepted when count < `FIFO_DEPTH`, or when slot i is popped in the same cycle.
- When a write and a pop on slot i coincide, the count is unchanged and both pointers advance.
- A write to a full slot with no pop is dropped, and `overflow[i]` sets.
- If a set and an `overflow_clr[i]` happen in the same cycle, the set wins.

**Load condition**
- `load` = (`!pkt_valid` || `pkt_ready`) && any slot non-empty.

**Arbitration** (registered round-robin)
- The winner is the first non-empty slot scanning upward from `last_grant`+1, modulo `NUM_PERIPHS`.
- On `load`:
  - `pkt_data` <= {winner, head[winner]}.
  - `pkt_valid` <= 1.
  - The winner's FIFO pops.
  - `last_grant` <= winner.
- If `pkt_ready` && `pkt_valid` && !`load`: `pkt_valid` <= 0 and `pkt_data` holds its value.
- While `pkt_valid` && !`pkt_ready`, `pkt_data` is stable and nothing pops.

**Packet content**
- Body bits pass through unmodified. That includes peripheral config responses (top body bits 11100); this block does not interpret them.

**Arithmetic**
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap naturally.
- Counts are log2(`FIFO_DEPTH`)+1 bits.

**Reset mid-operation**
- All state is cleared immediately. Queued packets are lost; no partial packet is emitted.

## Timing
- Latency: `rx_wren` at edge N puts the entry in the FIFO; `pkt_valid` rises at edge N+1 if the output is empty or `pkt_ready` is high.
- Throughput: one packet per cycle while `pkt_ready` stays high and any slot has data (back-to-back, no bubble).
- `rx_full` is combinational from the registered count. A peripheral that sees `rx_full` low may write in that cycle.
- `overflow` sets on the edge after the dropped write.

## Structure
- Shared package `usb_pkt_pkg`:
  - `usb_packet_width` = 32 and `periph_address_width` = 3, taken from `lycan_globals`.
  - `periph_body_t` (29 bits) and `usb_pkt_t` (packed struct: addr, body).
- Sub-module `periph_rx_slot_fifo`: one per slot, `FIFO_DEPTH` parameter.
  - Ports: wren, din, rden, dout, count, full, empty.
  - Honours the simultaneous write-when-full-with-pop rule.
- The arbiter, output register and overflow flags live in the top level.

## Test plan
- **Single packet:** after reset, write slot 2 with body 29'h0300_00AB while `pkt_ready`=1 → `pkt_valid` one cycle later, `pkt_data`=32'h4300_00AB, then `pkt_valid` drops.
- **Round-robin:** preload slots 0, 3, 5 with two packets each, then raise `pkt_ready`=1 → output order 0,3,5,0,3,5 on six consecutive cycles.
- **Backpressure:** `pkt_ready`=0 for 10 cycles with slot 1 holding data → `pkt_data` constant, slot 1 count unchanged; releasing `pkt_ready` drains in order.
- **Overflow:** with `pkt_ready`=0, write 5 packets to slot 4 (`FIFO_DEPTH`=4) →
  - After 3 writes: first packet in the output register, slot 4 holds 2, `rx_full[4]`=0.
  - After 5 writes: slot 4 holds 4 (writes 2–5) and `rx_full[4]`=1.
  - A 6th write is dropped and sets `overflow[4]`; `overflow_clr[4]` clears it.
  - Draining yields exactly packets 1–5.
- **Write-with-pop on a full slot:** slot 0 full and `pkt_ready`=1, write slot 0 in the same cycle as it is popped → write accepted, count stays 4, no overflow.
- **Async reset mid-stream:** assert `rst_n`=0 between clock edges during back-to-back traffic → `pkt_valid`, `rx_full` and `overflow` go 0 immediately; after release the first grant goes to the lowest non-empty slot.
